// File: rtl/aud_recorder_if.sv
// rtl/aud_recorder_if.sv - I2S capture control/data bundle for aud_recorder
// Purpose: groups the codec I2S pins, the control-FSM requests and the
//          SRAM write-side outputs of the ADC capture engine.
// Signals:
//   i_adclrck, i_adcdat         codec ADC LR clock and serial data
//   i_start, i_pause, i_stop    level requests from the top-level control FSM
//   o_address, o_data, o_valid  write strobe towards the SRAM arbiter
//   o_length, o_busy, o_done    capture status
// Modports: master = recorder side, slave = control/codec/arbiter side.
interface aud_recorder_if #(
  parameter int ADDR_W = 20
) ();
  logic              i_adclrck;
  logic              i_adcdat;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [ADDR_W-1:0] o_address;
  logic [15:0]       o_data;
  logic              o_valid;
  logic [ADDR_W-1:0] o_length;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_adclrck, i_adcdat, i_start, i_pause, i_stop,
    output o_address, o_data, o_valid, o_length, o_busy, o_done
  );

  modport slave (
    output i_adclrck, i_adcdat, i_start, i_pause, i_stop,
    input  o_address, o_data, o_valid, o_length, o_busy, o_done
  );
endinterface

// File: rtl/aud_recorder.sv
// rtl/aud_recorder.sv - I2S ADC capture engine producing 16-bit sample writes
// Purpose: deserialises the codec ADC bitstream (I2S, MSB first, one BCLK
//          after the LR edge) into 16-bit samples and issues one write strobe
//          per sample with an incrementing address. Start/pause/stop come
//          from the top-level control FSM.
// Ports:
//   i_bclk   codec bit clock, all logic on its rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      aud_recorder_if.master (I2S pins, control requests, write outputs)
// Parameters:
//   ADDR_W    width of sample address / length
//   MAX_ADDR  last writable address; must be odd in stereo builds
// Build option:
//   AUD_REC_STEREO_EN  defined: capture left+right (even/odd addresses);
//                      undefined: mono, left channel only.
module aud_recorder #(
  parameter int              ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input logic            i_bclk,
  input logic            i_rst_n,
  aud_recorder_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RECV  = 3'd2,
    S_WRITE = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              lrc_q, lrc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       shift_q, shift_d;
  logic              pause_q, pause_d;
  logic              ch_q, ch_d;        // 0 = capturing left, 1 = right
  logic [ADDR_W-1:0] address_q, address_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic [15:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              left_edge;
  logic              right_edge;
  logic              chan_edge;

  assign left_edge  = lrc_q & ~bus.i_adclrck;
  assign right_edge = ~lrc_q & bus.i_adclrck;
  assign chan_edge  = ch_q ? right_edge : left_edge;

  always_comb begin
    state_d   = state_q;
    lrc_d     = bus.i_adclrck;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    pause_d   = pause_q;
    ch_d      = ch_q;
    address_d = address_q;
    length_d  = length_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    // Outputs track the state one cycle late so they stay registered.
    busy_d    = (state_q != S_IDLE);

    if (bus.i_pause && (state_q == S_WAIT || state_q == S_RECV || state_q == S_WRITE)) begin
      pause_d = 1'b1;
    end

    // The strobe of the previous cycle commits the write: advance counters.
    // The address saturates at MAX_ADDR so it never wraps.
    if (valid_q) begin
      if (address_q != MAX_ADDR) begin
        address_d = address_q + 1'b1;
      end
      if (length_q != {ADDR_W{1'b1}}) begin
        length_d = length_q + 1'b1;
      end
      done_d = (address_q == MAX_ADDR);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_stop) begin
          state_d   = S_WAIT;
          address_d = '0;
          length_d  = '0;
          ch_d      = 1'b0;
        end
      end

      S_WAIT: begin
        if (bus.i_stop) begin
          state_d = S_IDLE;
        end else if (pause_d && !ch_q) begin
          // A waiting right channel must finish its frame first.
          state_d = S_PAUSE;
        end else if (chan_edge) begin
          state_d = S_RECV;
          cnt_d   = 4'd15;
        end
      end

      S_RECV: begin
        if (bus.i_stop) begin
          state_d = S_IDLE;
        end else begin
          shift_d[cnt_q] = bus.i_adcdat;
          cnt_d          = cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (bus.i_stop) begin
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
          data_d  = shift_q;
`ifdef AUD_REC_STEREO_EN
          if (!ch_q) begin
            ch_d    = 1'b1;
            state_d = S_WAIT;
          end else begin
            ch_d = 1'b0;
            if (address_q == MAX_ADDR) begin
              state_d = S_IDLE;
            end else if (pause_d) begin
              state_d = S_PAUSE;
            end else begin
              state_d = S_WAIT;
            end
          end
`else
          if (address_q == MAX_ADDR) begin
            state_d = S_IDLE;
          end else if (pause_d) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_WAIT;
          end
`endif
        end
      end

      S_PAUSE: begin
        if (bus.i_stop) begin
          state_d = S_IDLE;
        end else if (!bus.i_pause && bus.i_start) begin
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE || state_d == S_PAUSE) begin
      pause_d = 1'b0;
    end
    if (state_d == S_IDLE) begin
      ch_d = 1'b0;
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      // Preload with the live level so reset release never fakes an edge.
      lrc_q     <= bus.i_adclrck;
      cnt_q     <= 4'd15;
      shift_q   <= '0;
      pause_q   <= 1'b0;
      ch_q      <= 1'b0;
      address_q <= '0;
      length_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lrc_q     <= lrc_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      pause_q   <= pause_d;
      ch_q      <= ch_d;
      address_q <= address_d;
      length_q  <= length_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_address = address_q;
  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_length  = length_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_aud_recorder.sv
// tb/tb_aud_recorder.sv - self-checking bench for aud_recorder
// Drives I2S frames (32 BCLK per half-frame) with control pulses; expected
// writes are queued when a frame is driven and checked when o_valid fires.
// Build option AUD_REC_STEREO_EN selects the stereo scenarios.
module tb_aud_recorder;

  localparam int              ADDR_W = 20;
  localparam logic [ADDR_W-1:0] MAX  = 20'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              half;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aud_recorder_if #(.ADDR_W(ADDR_W)) bus ();

  aud_recorder #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX)) dut (
    .i_bclk  (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  exp_t e_m;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cur_half = 0;
  int   cur_bit  = 0;
  int   done_cnt = 0;
  time  last_valid_t = 0;
  time  done_t = 0;

  // Write monitor: sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.o_valid) begin
      last_valid_t = $time;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: addr=%0h data=%h, required no strobe", bus.o_address, bus.o_data);
      end else begin
        e_m = exp_q.pop_front();
        if (bus.o_address !== e_m.addr) begin
          n_fail++;
          $display("FAIL strobe_addr: got %0h, expected %0h", bus.o_address, e_m.addr);
        end
        n_assert++;
        if (bus.o_data !== e_m.data) begin
          n_fail++;
          $display("FAIL strobe_data: got %h, expected %h", bus.o_data, e_m.data);
        end
        n_assert++;
        if (cur_half != int'(e_m.half) || cur_bit != 17) begin
          n_fail++;
          $display("FAIL strobe_timing: got half %0d bit %0d, expected half %0d bit 17", cur_half, cur_bit, e_m.half);
        end
      end
    end
    if (rst_n && bus.o_done) begin
      done_cnt++;
      done_t = $time;
    end
  end

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int pause_bit, input int stop_bit);
    logic [15:0] w;
    for (int h = 0; h < 2; h++) begin
      w = (h == 0) ? l : r;
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        cur_half = h;
        cur_bit  = b;
        if (b == 0) bus.i_adclrck = (h == 1);
        bus.i_adcdat = (b >= 1 && b <= 16) ? w[16-b] : 1'b0;
        bus.i_pause  = (h == 0 && b == pause_bit);
        bus.i_stop   = (h == 0 && b == stop_bit);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic h);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.half = h;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_strobes: got %0d pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert += 4;
    if (bus.o_address !== '0) begin n_fail++; $display("FAIL reset_address: got %0h, expected 0", bus.o_address); end
    if (bus.o_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", bus.o_data); end
    if (bus.o_length !== '0) begin n_fail++; $display("FAIL reset_length: got %0h, expected 0", bus.o_length); end
    if ({bus.o_valid, bus.o_busy, bus.o_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 000", {bus.o_valid, bus.o_busy, bus.o_done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifndef AUD_REC_STEREO_EN
  task automatic test_basic();
    pulse_start();
    @(posedge clk);
    #1;
    n_assert++;
    if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, expected 1", bus.o_busy); end
    push(0, 16'hA5C3, 1'b0);
    push(1, 16'h8001, 1'b0);
    push(2, 16'h7FFE, 1'b0);
    frame(16'hA5C3, 16'h1111, -1, -1);
    frame(16'h8001, 16'h2222, -1, -1);
    frame(16'h7FFE, 16'h3333, -1, -1);
    n_assert += 3;
    if (bus.o_length !== 20'd3) begin n_fail++; $display("FAIL basic_length: got %0d, expected 3", bus.o_length); end
    if (bus.o_address !== 20'd3) begin n_fail++; $display("FAIL basic_address: got %0d, expected 3", bus.o_address); end
    if (bus.o_data !== 16'h7FFE) begin n_fail++; $display("FAIL basic_data_hold: got %h, expected 7ffe", bus.o_data); end
    check_drained("basic");
    pulse_stop();
  endtask

  task automatic test_stop();
    pulse_start();
    push(0, 16'h1357, 1'b0);
    frame(16'h1357, 16'h0F0F, -1, -1);
    frame(16'h2468, 16'h0F0F, -1, 8);
    n_assert += 3;
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b, expected 0", bus.o_busy); end
    if (bus.o_length !== 20'd1) begin n_fail++; $display("FAIL stop_length: got %0d, expected 1", bus.o_length); end
    if (bus.o_address !== 20'd1) begin n_fail++; $display("FAIL stop_address: got %0d, expected 1", bus.o_address); end
    pulse_start();
    push(0, 16'hC3A5, 1'b0);
    frame(16'hC3A5, 16'h0F0F, -1, -1);
    n_assert++;
    if (bus.o_length !== 20'd1) begin n_fail++; $display("FAIL stop_restart_length: got %0d, expected 1", bus.o_length); end
    check_drained("stop");
    pulse_stop();
  endtask

  task automatic test_pause();
    logic [15:0] d;
    pulse_start();
    push(0, 16'h0246, 1'b0);
    frame(16'h0246, 16'hFFFF, -1, -1);
    push(1, 16'hBEEF, 1'b0);
    frame(16'hBEEF, 16'hFFFF, 6, -1);
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom_range(0, 65535));
      frame(d, ~d, -1, -1);
    end
    n_assert += 2;
    if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL pause_busy: got %b, expected 1", bus.o_busy); end
    if (bus.o_length !== 20'd2) begin n_fail++; $display("FAIL pause_length: got %0d, expected 2", bus.o_length); end
    pulse_start();
    push(2, 16'h9ABC, 1'b0);
    frame(16'h9ABC, 16'h0000, -1, -1);
    n_assert++;
    if (bus.o_length !== 20'd3) begin n_fail++; $display("FAIL pause_resume_length: got %0d, expected 3", bus.o_length); end
    check_drained("pause");
    pulse_stop();
  endtask

  task automatic test_max();
    logic [15:0] d [6];
    for (int i = 0; i < 6; i++) d[i] = 16'($urandom_range(0, 65535));
    pulse_start();
    for (int i = 0; i < 4; i++) push(ADDR_W'(i), d[i], 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) frame(d[i], 16'h5555, -1, -1);
    n_assert += 4;
    if (done_cnt != 1) begin n_fail++; $display("FAIL max_done_count: got %0d, expected 1", done_cnt); end
    if (done_t - last_valid_t != 10) begin n_fail++; $display("FAIL max_done_timing: got %0t, expected 10", done_t - last_valid_t); end
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL max_busy: got %b, expected 0", bus.o_busy); end
    if (bus.o_length !== 20'd4) begin n_fail++; $display("FAIL max_length: got %0d, expected 4", bus.o_length); end
    check_drained("max");
  endtask

  task automatic test_start_stop_reset();
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL startstop_busy: got %b, expected 0", bus.o_busy); end
    frame(16'h4321, 16'h8765, -1, -1);
    pulse_start();
    push(0, 16'hC0DE, 1'b0);
    frame(16'hC0DE, 16'h0000, -1, -1);
    n_assert++;
    if (bus.o_data !== 16'hC0DE) begin n_fail++; $display("FAIL prereset_data: got %h, expected c0de", bus.o_data); end
    fork
      frame(16'hFACE, 16'h0000, -1, -1);
      begin
        repeat (11) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_assert += 3;
        if (bus.o_data !== 16'h0 || bus.o_address !== '0) begin
          n_fail++; $display("FAIL async_reset_data_addr: got %h/%0h, expected 0/0", bus.o_data, bus.o_address);
        end
        if (bus.o_length !== '0) begin n_fail++; $display("FAIL async_reset_length: got %0d, expected 0", bus.o_length); end
        if ({bus.o_valid, bus.o_busy, bus.o_done} !== 3'b000) begin
          n_fail++; $display("FAIL async_reset_flags: got %b, expected 000", {bus.o_valid, bus.o_busy, bus.o_done});
        end
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    check_drained("reset");
  endtask
`else
  task automatic test_stereo();
    pulse_start();
    push(0, 16'h1234, 1'b0);
    push(1, 16'hFEDC, 1'b1);
    frame(16'h1234, 16'hFEDC, -1, -1);
    n_assert++;
    if (bus.o_length !== 20'd2) begin n_fail++; $display("FAIL stereo_length: got %0d, expected 2", bus.o_length); end
    check_drained("stereo");
    pulse_stop();
    pulse_start();
    push(0, 16'hAAAA, 1'b0);
    push(1, 16'h5555, 1'b1);
    frame(16'hAAAA, 16'h5555, 6, -1);
    frame(16'h0F0F, 16'hF0F0, -1, -1);
    n_assert += 2;
    if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL stereo_pause_busy: got %b, expected 1", bus.o_busy); end
    if (bus.o_length !== 20'd2) begin n_fail++; $display("FAIL stereo_pause_length: got %0d, expected 2", bus.o_length); end
    check_drained("stereo_pause");
    pulse_stop();
  endtask
`endif

  initial begin
    bus.i_adclrck = 1'b1;
    bus.i_adcdat  = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_pause   = 1'b0;
    bus.i_stop    = 1'b0;
    test_reset();
`ifndef AUD_REC_STEREO_EN
    test_basic();
    test_stop();
    test_pause();
    test_max();
    test_start_stop_reset();
`else
    test_stereo();
`endif
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
